// File: rtl/i2c_slave.sv
// Write-only I2C slave that collects NUM_BYTE bytes behind SLAVE_ADDR and posts them as one word on STOP.
// Latency: bus events act 3 clk after the pin change (5 clk with I2C_SLAVE_GLITCH_FILTER_EN); rdata_vld follows STOP by that latency.
// Backpressure: none toward the fabric (readdata is held, rdata_vld pulses once); toward the bus, reads and surplus bytes are NACKed.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         NUM_BYTE   = 4,
    parameter int         BYTE_SIZE  = 8,
    parameter int         DATA_WIDTH = NUM_BYTE * BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2c_SCL,
    inout  wire                   i2c_SDA,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  rdata_vld,
    output logic                  busy,
    output logic                  err_short,
    output logic                  err_overrun
);

    localparam int BIT_W = $clog2(BYTE_SIZE);
    localparam int CNT_W = $clog2(NUM_BYTE + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BYTE);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
        logic sda;
    } bus_evt_t;

    // Index 0 carries SCL, index 1 carries SDA; idle-high reset avoids a fake edge after reset.
    logic [1:0] sync1, sync2, line, line_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {i2c_SDA, i2c_SCL};
            sync2 <= sync1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] win0, win1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win0 <= 2'b11;
            win1 <= 2'b11;
            line <= 2'b11;
        end else begin
            win0 <= sync2;
            win1 <= win0;
            line <= (sync2 & win0) | (sync2 & win1) | (win0 & win1);
        end
    end
`else
    assign line = sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) line_hist <= 2'b11;
        else      line_hist <= line;
    end

    bus_evt_t evt;

    always_comb begin
        evt.scl_rise = line[0] & ~line_hist[0];
        evt.scl_fall = ~line[0] & line_hist[0];
        evt.start    = line[0] & line_hist[0] & line_hist[1] & ~line[1];
        evt.stop     = line[0] & line_hist[0] & ~line_hist[1] & line[1];
        evt.sda      = line[1];
    end

    state_t                state, state_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [BYTE_SIZE-1:0]  shreg, shreg_n, rx_byte;
    logic [CNT_W-1:0]      byte_cnt, byte_cnt_n;
    logic [DATA_WIDTH-1:0] shadow, shadow_n, readdata_n;
    logic                  sda_low, sda_low_n;
    logic                  busy_n, rdata_vld_n, err_short_n, err_overrun_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_cnt    <= '0;
            shadow      <= '0;
            sda_low     <= 1'b0;
            busy        <= 1'b0;
            readdata    <= '0;
            rdata_vld   <= 1'b0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            byte_cnt    <= byte_cnt_n;
            shadow      <= shadow_n;
            sda_low     <= sda_low_n;
            busy        <= busy_n;
            readdata    <= readdata_n;
            rdata_vld   <= rdata_vld_n;
            err_short   <= err_short_n;
            err_overrun <= err_overrun_n;
        end
    end

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shreg_n       = shreg;
        byte_cnt_n    = byte_cnt;
        shadow_n      = shadow;
        sda_low_n     = sda_low;
        busy_n        = busy;
        readdata_n    = readdata;
        rdata_vld_n   = 1'b0;
        err_short_n   = 1'b0;
        err_overrun_n = 1'b0;
        rx_byte       = {shreg[BYTE_SIZE-2:0], evt.sda};

        if (evt.start) begin
            // Repeated START abandons whatever was collected so far.
            state_n    = ADDR;
            bit_cnt_n  = '0;
            byte_cnt_n = '0;
            shadow_n   = '0;
            sda_low_n  = 1'b0;
        end else if (evt.stop) begin
            if (state != IDLE) begin
                state_n    = IDLE;
                busy_n     = 1'b0;
                sda_low_n  = 1'b0;
                bit_cnt_n  = '0;
                byte_cnt_n = '0;
                if (byte_cnt == FULL_CNT) begin
                    readdata_n  = shadow;
                    rdata_vld_n = 1'b1;
                end else if (byte_cnt != '0) begin
                    err_short_n = 1'b1;
                end
            end
        end else begin
            case (state)
                ADDR: begin
                    if (evt.scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            if (rx_byte[7:1] == SLAVE_ADDR && !rx_byte[0]) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // First SCL fall opens the ACK slot, the second one closes it.
                    if (evt.scl_fall) begin
                        if (!sda_low) begin
                            sda_low_n = 1'b1;
                        end else begin
                            sda_low_n = 1'b0;
                            state_n   = DATA;
                            bit_cnt_n = '0;
                        end
                    end
                end
                DATA: begin
                    if (evt.scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            if (byte_cnt < FULL_CNT) begin
                                for (int i = 0; i < NUM_BYTE; i++) begin
                                    if (byte_cnt == CNT_W'(i))
                                        shadow_n[DATA_WIDTH-1-i*BYTE_SIZE -: BYTE_SIZE] = rx_byte;
                                end
                                byte_cnt_n = byte_cnt + 1'b1;
                                state_n    = DATA_ACK;
                            end else begin
                                err_overrun_n = 1'b1;
                                state_n       = IGNORE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset gates the pull-down directly so the bus is freed without waiting for a clock.
    assign i2c_SDA = (rst && sda_low) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a behavioural I2C master writes framed transactions and checks ACKs and outputs.
module tb_i2c_slave;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic [31:0] readdata;
    logic        rdata_vld, busy, err_short, err_overrun;

    int n_chk = 0;
    int n_pass = 0;
    int vld_cnt = 0, short_cnt = 0, ovr_cnt = 0, busy_cyc = 0;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk        (clk),
        .rst        (rst),
        .i2c_SCL    (scl),
        .i2c_SDA    (sda),
        .readdata   (readdata),
        .rdata_vld  (rdata_vld),
        .busy       (busy),
        .err_short  (err_short),
        .err_overrun(err_overrun)
    );

    always @(negedge clk) begin
        if (rdata_vld)   vld_cnt++;
        if (err_short)   short_cnt++;
        if (err_overrun) ovr_cnt++;
        if (busy)        busy_cyc++;
    end

    task automatic wq;
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_start;
        m_low = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        m_low = 1'b1;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic send_stop;
        m_low = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        m_low = 1'b0;
        wq();
        wq();
    endtask

    task automatic write_bit(input logic b, input bit glitch);
        m_low = ~b;
        if (glitch) begin
            repeat (3) @(negedge clk);
            scl = 1'b1;
            @(negedge clk);
            scl = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            wq();
        end
        scl = 1'b1;
        wq();
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gl);
        for (int i = 7; i >= 0; i--) write_bit(b[i], i == gl);
    endtask

    task automatic ack_slot(output logic a);
        m_low = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        a = sda;
        wq();
        scl = 1'b0;
        wq();
    endtask

    // acks[0] is the address slot; the master stops at the first NACK.
    task automatic xfer(input logic [7:0] addr_byte, input int nbytes,
                        input logic [63:0] data, output logic [8:0] acks);
        logic a;
        acks = '1;
        send_start();
        send_byte(addr_byte, -1);
        ack_slot(a);
        acks[0] = a;
        if (!a) begin
            for (int i = 0; i < nbytes; i++) begin
                send_byte(data[63-8*i -: 8], -1);
                ack_slot(a);
                acks[i+1] = a;
                if (a) break;
            end
        end
        send_stop();
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        n_chk++; if (readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=0", readdata); else n_pass++;
        n_chk++; if (rdata_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", rdata_vld); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (err_short !== 1'b0) $display("FAIL reset_err_short got=%b exp=0", err_short); else n_pass++;
        n_chk++; if (err_overrun !== 1'b0) $display("FAIL reset_err_overrun got=%b exp=0", err_overrun); else n_pass++;
        n_chk++; if (sda !== 1'b1) $display("FAIL reset_sda got=%b exp=1", sda); else n_pass++;
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write;
        logic [8:0] acks;
        int v0, s0, o0, b0;
        v0 = vld_cnt; s0 = short_cnt; o0 = ovr_cnt; b0 = busy_cyc;
        xfer(8'haa, 4, 64'hdeadbeef_00000000, acks);
        n_chk++; if (acks[4:0] !== 5'b0) $display("FAIL write_acks got=%b exp=00000", acks[4:0]); else n_pass++;
        n_chk++; if (readdata !== 32'hdeadbeef) $display("FAIL write_readdata got=%h exp=deadbeef", readdata); else n_pass++;
        n_chk++; if (vld_cnt - v0 !== 1) $display("FAIL write_vld_cycles got=%0d exp=1", vld_cnt - v0); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL write_busy_after got=%b exp=0", busy); else n_pass++;
        n_chk++; if (busy_cyc == b0) $display("FAIL write_busy_during got=%0d cycles exp>0", busy_cyc - b0); else n_pass++;
        n_chk++; if ((short_cnt - s0) + (ovr_cnt - o0) !== 0)
            $display("FAIL write_err_pulses got=%0d exp=0", (short_cnt - s0) + (ovr_cnt - o0)); else n_pass++;
    endtask

    task automatic test_bad_addr;
        logic [8:0] acks;
        int v0, b0;
        v0 = vld_cnt; b0 = busy_cyc;
        xfer(8'he0, 4, 64'h12345678_00000000, acks);
        n_chk++; if (acks[0] !== 1'b1) $display("FAIL badaddr_ack got=%b exp=1", acks[0]); else n_pass++;
        n_chk++; if (vld_cnt - v0 !== 0) $display("FAIL badaddr_vld got=%0d exp=0", vld_cnt - v0); else n_pass++;
        n_chk++; if (readdata !== 32'hdeadbeef) $display("FAIL badaddr_readdata got=%h exp=deadbeef", readdata); else n_pass++;
        n_chk++; if (busy_cyc - b0 !== 0) $display("FAIL badaddr_busy got=%0d exp=0", busy_cyc - b0); else n_pass++;
    endtask

    task automatic test_read_req;
        logic [8:0] acks;
        int v0, s0, o0;
        v0 = vld_cnt; s0 = short_cnt; o0 = ovr_cnt;
        xfer(8'hab, 4, 64'h0, acks);
        n_chk++; if (acks[0] !== 1'b1) $display("FAIL read_ack got=%b exp=1", acks[0]); else n_pass++;
        n_chk++; if ((vld_cnt - v0) + (short_cnt - s0) + (ovr_cnt - o0) !== 0)
            $display("FAIL read_pulses got=%0d exp=0", (vld_cnt - v0) + (short_cnt - s0) + (ovr_cnt - o0)); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL read_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_short;
        logic [8:0] acks;
        int v0, s0;
        v0 = vld_cnt; s0 = short_cnt;
        xfer(8'haa, 2, 64'habcd0000_00000000, acks);
        n_chk++; if (acks[2:0] !== 3'b0) $display("FAIL short_acks got=%b exp=000", acks[2:0]); else n_pass++;
        n_chk++; if (short_cnt - s0 !== 1) $display("FAIL short_err_cycles got=%0d exp=1", short_cnt - s0); else n_pass++;
        n_chk++; if (readdata !== 32'hdeadbeef) $display("FAIL short_readdata got=%h exp=deadbeef", readdata); else n_pass++;
        n_chk++; if (vld_cnt - v0 !== 0) $display("FAIL short_vld got=%0d exp=0", vld_cnt - v0); else n_pass++;
    endtask

    task automatic test_overrun;
        logic [8:0] acks;
        int v0, s0, o0;
        v0 = vld_cnt; s0 = short_cnt; o0 = ovr_cnt;
        xfer(8'haa, 5, 64'h01020304_05000000, acks);
        n_chk++; if (acks[5:0] !== 6'b100000) $display("FAIL ovr_acks got=%b exp=100000", acks[5:0]); else n_pass++;
        n_chk++; if (ovr_cnt - o0 !== 1) $display("FAIL ovr_err_cycles got=%0d exp=1", ovr_cnt - o0); else n_pass++;
        n_chk++; if (vld_cnt - v0 !== 1) $display("FAIL ovr_vld got=%0d exp=1", vld_cnt - v0); else n_pass++;
        n_chk++; if (readdata !== 32'h01020304) $display("FAIL ovr_readdata got=%h exp=01020304", readdata); else n_pass++;
        n_chk++; if (short_cnt - s0 !== 0) $display("FAIL ovr_short got=%0d exp=0", short_cnt - s0); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic       a;
        logic [8:0] acks;
        int         v0;
        send_start();
        send_byte(8'haa, -1);
        ack_slot(a);
        send_byte(8'h12, -1);
        ack_slot(a);
        send_byte(8'h34, -1);
        m_low = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        n_chk++; if (sda !== 1'b0) $display("FAIL rstmid_ack_before got=%b exp=0", sda); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (sda !== 1'b1) $display("FAIL rstmid_sda_released got=%b exp=1", sda); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (readdata !== 32'h0) $display("FAIL rstmid_readdata got=%h exp=0", readdata); else n_pass++;
        wq();
        rst = 1'b1;
        wq();
        v0 = vld_cnt;
        xfer(8'haa, 4, 64'h11111111_00000000, acks);
        n_chk++; if (acks[4:0] !== 5'b0) $display("FAIL rstmid_acks got=%b exp=00000", acks[4:0]); else n_pass++;
        n_chk++; if (readdata !== 32'h11111111) $display("FAIL rstmid_readdata_new got=%h exp=11111111", readdata); else n_pass++;
        n_chk++; if (vld_cnt - v0 !== 1) $display("FAIL rstmid_vld got=%0d exp=1", vld_cnt - v0); else n_pass++;
    endtask

    task automatic test_repeated_start;
        logic       a;
        logic [8:0] acks;
        int         v0, s0;
        v0 = vld_cnt; s0 = short_cnt;
        send_start();
        send_byte(8'haa, -1);
        ack_slot(a);
        send_byte(8'hcc, -1);
        ack_slot(a);
        send_byte(8'hdd, -1);
        ack_slot(a);
        xfer(8'haa, 4, 64'hcafef00d_00000000, acks);
        n_chk++; if (readdata !== 32'hcafef00d) $display("FAIL rstart_readdata got=%h exp=cafef00d", readdata); else n_pass++;
        n_chk++; if (vld_cnt - v0 !== 1) $display("FAIL rstart_vld got=%0d exp=1", vld_cnt - v0); else n_pass++;
        n_chk++; if (short_cnt - s0 !== 0) $display("FAIL rstart_short got=%0d exp=0", short_cnt - s0); else n_pass++;
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch;
        logic a;
        int   v0;
        v0 = vld_cnt;
        send_start();
        send_byte(8'haa, -1);
        ack_slot(a);
        send_byte(8'ha5, 3);
        ack_slot(a);
        send_byte(8'h5a, -1);
        ack_slot(a);
        send_byte(8'h0f, 6);
        ack_slot(a);
        send_byte(8'hf0, -1);
        ack_slot(a);
        send_stop();
        n_chk++; if (readdata !== 32'ha55a0ff0) $display("FAIL glitch_readdata got=%h exp=a55a0ff0", readdata); else n_pass++;
        n_chk++; if (vld_cnt - v0 !== 1) $display("FAIL glitch_vld got=%0d exp=1", vld_cnt - v0); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_bad_addr();
        test_read_req();
        test_short();
        test_overrun();
        test_reset_mid();
        test_repeated_start();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Synthesizable I2C slave receiver; the downstream consumer of i2c_master's bus traffic.
- Decodes START/STOP, matches its 7-bit address, receives NUM_BYTE write bytes MSB-first and ACKs each one.
- Presents the assembled word to the fabric with a one-cycle valid pulse.
- Write-only; read requests are NACKed.

Parameters:
- SLAVE_ADDR, 7'h55, 7-bit bus address this slave responds to.
- NUM_BYTE, 4, data bytes per transaction (excludes the address byte).
- BYTE_SIZE, 8, bits per byte.
- DATA_WIDTH, NUM_BYTE*BYTE_SIZE, width of the received word.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- i2c_SCL  input  1  I2C clock from the master.
- i2c_SDA  inout  1  I2C data, open-drain: the block drives 0 or Z only.
- readdata  output  DATA_WIDTH  received word; the first byte on the wire is in [DATA_WIDTH-1 -: 8].
- rdata_vld  output  1  one-cycle pulse when readdata is updated.
- busy  output  1  high from an address match to STOP.
- err_short  output  1  one-cycle pulse: STOP arrived before NUM_BYTE bytes were received.
- err_overrun  output  1  one-cycle pulse: master sent a byte beyond NUM_BYTE.

Behaviour:
- Reset (rst=0, asynchronous):
  - readdata=0, rdata_vld=0, busy=0, err_short=0, err_overrun=0.
  - SDA released; state=IDLE.
- Input synchronizer:
  - SCL and SDA each pass through a 2-flop synchronizer plus one history flop.
  - Events (SCL rise, SCL fall, START, STOP) are detected 3 clk after the pin change.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and take priority over bit sampling.
- Bit handling:
  - Bits are sampled on SCL rise and shifted MSB-first into an 8-bit shift register.
  - A 3-bit bit counter is cleared on START and after each ACK slot.
- States:
  - IDLE: START -> ADDR.
  - ADDR: after the 8th bit:
    - if addr[7:1]==SLAVE_ADDR and addr[0]==0 (write) -> ADDR_ACK, busy=1;
    - otherwise -> IGNORE (no ACK).
  - ADDR_ACK: on the SCL fall after the 8th bit, drive SDA low; release on the next SCL fall -> DATA.
  - DATA: after the 8th bit:
    - if byte_cnt<NUM_BYTE: store the byte into readdata_shadow at position byte_cnt from the top, increment byte_cnt, -> DATA_ACK;
    - otherwise: pulse err_overrun, do not ACK -> IGNORE.
  - DATA_ACK: same ACK timing as ADDR_ACK -> DATA.
  - IGNORE: SDA released; waits for START or STOP.
- STOP from any non-IDLE state -> IDLE, busy=0:
  - if byte_cnt==NUM_BYTE: readdata <= shadow and rdata_vld=1 for exactly one clk;
  - if 0<byte_cnt<NUM_BYTE: err_short pulse; readdata unchanged.
- Repeated START in any state -> ADDR; byte_cnt=0; shadow discarded; no pulses.
- readdata holds its value between transactions.
- rst low mid-transaction: SDA is released immediately (combinational from the async reset), all state clears, and the next activity must be a new START.
- SDA is never driven low outside an ACK slot.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined:
  - SCL and SDA pass through a 3-sample majority filter after the synchronizer.
  - Pulses of 1 clk are suppressed.
  - Event latency becomes 5 clk.
- Undefined:
  - No filter; 3 clk latency.
  - A 1-clk glitch on SCL is treated as a real edge.

Test Plan:
- Master writes addr 7'h55, data 32'hdeadbeef -> ACK low on 5 slots; readdata=32'hdeadbeef; rdata_vld high exactly 1 clk after STOP; busy low.
- Master writes addr 7'h70 -> no ACK (SDA stays high in slot 9); the master reports its no-ack error; no rdata_vld; readdata unchanged.
- Addr 7'h55 with R/W=1 -> NACK; IGNORE until STOP; no pulses.
- Addr 7'h55, 2 bytes 8'hab, 8'hcd, then STOP -> err_short 1-clk pulse; readdata still holds 32'hdeadbeef.
- Addr 7'h55, 5 bytes -> first 4 ACKed, 5th NACKed, err_overrun pulse; at STOP, rdata_vld=1 and readdata holds the first 4 bytes.
- rst asserted during byte 2 of a write -> SDA Z immediately; then a full write of 32'h11111111 succeeds. With I2C_SLAVE_GLITCH_FILTER_EN, a 1-clk SCL glitch mid-byte -> data is still received correctly.
